isr_sequencer: RTL and testbench

Interrupt sequencer for the three IO modules (IO2, IO1, IO0). It latches normal and fast interrupt requests and raises a single request to the CPU. On CPU acknowledge it grants by priority and drives the 3-bit current-ISR code consumed by the current-ISR decoder (0 idle, 1–3 normal IO2/IO1/IO0, 4–6 fast IO2/IO1/IO0). It tracks ISR completion, including one level of fast-over-normal nesting.

---
 rtl/isr_sequencer.sv | 162 ++++++++++++++++
 tb/tb_isr_sequencer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/isr_sequencer.sv
// Interrupt sequencer for IO2/IO1/IO0: captures normal/fast request edges, requests the CPU, grants by priority.
// Optional one-level fast-over-normal nesting is enabled by defining FIQ_NEST_EN.
module isr_sequencer (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [2:0] irq,
   input  logic [2:0] firq,
   input  logic       int_en,
   input  logic       int_ack,
   input  logic       isr_done,
   output logic       int_req,
   output logic [2:0] int_vec,
   output logic [2:0] cur_isr,
   output logic [5:0] pend,
   output logic       nested
);

   localparam int unsigned NSRC = 3;
   localparam int unsigned PW   = 2 * NSRC;
   localparam int unsigned CW   = 3;

   typedef enum logic [1:0] {IDLE, REQ, NSVC, FSVC} state_t;

   state_t          state, state_nxt;
   logic [NSRC-1:0] irq_q, firq_q;
   logic [PW-1:0]   rise, clr, pend_nxt;
   logic            int_req_nxt, ack;
   logic [CW-1:0]   int_vec_nxt, cur_isr_nxt;

   // Highest pending source: any fast beats any normal, IO2 > IO1 > IO0 within a class.
   function automatic logic [CW-1:0] prio(input logic [PW-1:0] p);
      if (p[5])      return CW'(4);
      else if (p[4]) return CW'(5);
      else if (p[3]) return CW'(6);
      else if (p[2]) return CW'(1);
      else if (p[1]) return CW'(2);
      else if (p[0]) return CW'(3);
      else           return CW'(0);
   endfunction

   function automatic logic [PW-1:0] grant_mask(input logic [CW-1:0] c);
      case (c)
         3'd1:    return PW'(6'b000100);
         3'd2:    return PW'(6'b000010);
         3'd3:    return PW'(6'b000001);
         3'd4:    return PW'(6'b100000);
         3'd5:    return PW'(6'b010000);
         3'd6:    return PW'(6'b001000);
         default: return '0;
      endcase
   endfunction

   assign rise = {firq & ~firq_q, irq & ~irq_q};
   // An ack counts only during a request cycle and loses to a same-cycle done.
   assign ack  = int_ack & int_req & ~isr_done;

`ifdef FIQ_NEST_EN
   logic [CW-1:0] saved, saved_nxt;
   logic          nested_nxt;
`endif

   always_comb begin
      state_nxt   = state;
      cur_isr_nxt = cur_isr;
      clr         = '0;
      int_req_nxt = 1'b0;
`ifdef FIQ_NEST_EN
      saved_nxt   = saved;
      nested_nxt  = nested;
`endif
      case (state)
         IDLE: if (int_en && (|pend)) state_nxt = REQ;
         REQ: begin
            if (isr_done && int_ack) begin
               state_nxt = IDLE;
            end else if (ack) begin
               cur_isr_nxt = int_vec;
               clr         = grant_mask(int_vec);
               state_nxt   = int_vec[2] ? FSVC : NSVC;
            end else if (!int_en) begin
               state_nxt = IDLE;
            end
         end
         NSVC: begin
            if (isr_done) begin
               cur_isr_nxt = '0;
               state_nxt   = IDLE;
            end
`ifdef FIQ_NEST_EN
            else if (ack) begin
               saved_nxt   = cur_isr;
               nested_nxt  = 1'b1;
               cur_isr_nxt = int_vec;
               clr         = grant_mask(int_vec);
               state_nxt   = FSVC;
            end
`endif
         end
         FSVC: begin
            if (isr_done) begin
`ifdef FIQ_NEST_EN
               if (nested) begin
                  cur_isr_nxt = saved;
                  nested_nxt  = 1'b0;
                  state_nxt   = NSVC;
               end else
`endif
               begin
                  cur_isr_nxt = '0;
                  state_nxt   = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase

      // Set wins over a same-cycle grant clear.
      pend_nxt = (pend & ~clr) | rise;

      if (state_nxt == REQ) int_req_nxt = 1'b1;
`ifdef FIQ_NEST_EN
      else if (state == NSVC && state_nxt == NSVC && int_en && (|pend[5:3])) int_req_nxt = 1'b1;
`endif
      int_vec_nxt = int_req_nxt ? prio(pend_nxt) : '0;
   end

   // Edge-detect registers reset high so inputs already asserted at release are not captured.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         irq_q   <= '1;
         firq_q  <= '1;
         pend    <= '0;
         int_req <= 1'b0;
         int_vec <= '0;
         cur_isr <= '0;
      end else begin
         state   <= state_nxt;
         irq_q   <= irq;
         firq_q  <= firq;
         pend    <= pend_nxt;
         int_req <= int_req_nxt;
         int_vec <= int_vec_nxt;
         cur_isr <= cur_isr_nxt;
      end
   end

`ifdef FIQ_NEST_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         saved  <= '0;
         nested <= 1'b0;
      end else begin
         saved  <= saved_nxt;
         nested <= nested_nxt;
      end
   end
`else
   assign nested = 1'b0;
`endif

endmodule

// File: tb/tb_isr_sequencer.sv
// Scoreboarded bench for isr_sequencer: grant codes are queued at request time and checked at each grant.
module tb_isr_sequencer;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [2:0] irq = '0, firq = '0;
   logic       int_en = 1'b1, int_ack = 1'b0, isr_done = 1'b0;
   logic       int_req, nested;
   logic [2:0] int_vec, cur_isr;
   logic [5:0] pend;

   int unsigned vectors = 0, miscompares = 0;
   logic [2:0]  exp_q[$];

   isr_sequencer dut (
      .clk(clk), .reset_n(reset_n), .irq(irq), .firq(firq), .int_en(int_en),
      .int_ack(int_ack), .isr_done(isr_done), .int_req(int_req), .int_vec(int_vec),
      .cur_isr(cur_isr), .pend(pend), .nested(nested)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_req(input string tag);
      for (int i = 0; i < 20 && !int_req; i++) tick();
      check({tag, "_req"}, 8'(int_req), 8'd1);
   endtask

   // Ack the pending request and compare the granted code with the scoreboard head.
   task automatic grant(input string tag);
      logic [2:0] e;
      wait_req(tag);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 3'd0;
      check({tag, "_vec"}, 8'(int_vec), 8'(e));
      int_ack = 1'b1;
      tick();
      int_ack = 1'b0;
      check({tag, "_cur"}, 8'(cur_isr), 8'(e));
      check({tag, "_req_low"}, 8'(int_req), 8'd0);
   endtask

   task automatic done(input string tag, input logic [2:0] exp_cur);
      isr_done = 1'b1;
      tick();
      isr_done = 1'b0;
      check({tag, "_done_cur"}, 8'(cur_isr), 8'(exp_cur));
   endtask

   initial begin
      // reset state
      @(posedge clk);
      #1;
      check("rst_req", 8'(int_req), 8'd0);
      check("rst_vec", 8'(int_vec), 8'd0);
      check("rst_cur", 8'(cur_isr), 8'd0);
      check("rst_pend", 8'(pend), 8'd0);
      check("rst_nested", 8'(nested), 8'd0);
      reset_n = 1'b1;
      tick(); tick();

      // single normal request, exact latency
      irq = 3'b010; exp_q.push_back(3'd2);
      tick();
      check("t1_pend", 8'(pend), 8'h02);
      check("t1_req_early", 8'(int_req), 8'd0);
      tick();
      check("t1_req", 8'(int_req), 8'd1);
      grant("t1");
      check("t1_pend_clr", 8'(pend), 8'h00);
      done("t1", 3'd0);
      tick();
      check("t1_idle_req", 8'(int_req), 8'd0);
      irq = '0; tick();

      // priority order across classes
      irq = 3'b111; firq = 3'b001;
      exp_q.push_back(3'd6); exp_q.push_back(3'd1); exp_q.push_back(3'd2); exp_q.push_back(3'd3);
      for (int k = 0; k < 4; k++) begin
         grant($sformatf("t2_%0d", k));
         done($sformatf("t2_%0d", k), 3'd0);
         if (k < 3) begin
            tick();
            check($sformatf("t2_rereq_%0d", k), 8'(int_req), 8'd1);
         end
      end
      irq = '0; firq = '0; tick(); tick();

      // global enable gating
      int_en = 1'b0; irq = 3'b001; exp_q.push_back(3'd3);
      tick(); tick(); tick();
      check("t3_req_off", 8'(int_req), 8'd0);
      check("t3_pend", 8'(pend), 8'h01);
      int_en = 1'b1;
      tick();
      check("t3_req_on", 8'(int_req), 8'd1);
      check("t3_vec", 8'(int_vec), 8'd3);
      grant("t3");
      done("t3", 3'd0);
      irq = '0; tick();

      // fast request while a normal ISR runs
      irq = 3'b001; exp_q.push_back(3'd3);
      grant("t4n");
      firq = 3'b100; exp_q.push_back(3'd4);
      tick(); tick();
`ifdef FIQ_NEST_EN
      check("t4_nest_req", 8'(int_req), 8'd1);
      check("t4_nest_vec", 8'(int_vec), 8'd4);
      grant("t4f");
      check("t4_nested", 8'(nested), 8'd1);
      done("t4_restore", 3'd3);
      check("t4_unnested", 8'(nested), 8'd0);
      done("t4_last", 3'd0);
`else
      check("t4_no_preempt", 8'(int_req), 8'd0);
      check("t4_cur_hold", 8'(cur_isr), 8'd3);
      done("t4n", 3'd0);
      grant("t4f");
      done("t4f", 3'd0);
`endif
      irq = '0; firq = '0; tick(); tick();

      // ack+done collision, then set-wins-over-clear on grant
      irq = 3'b010; exp_q.push_back(3'd2);
      wait_req("t5");
      int_ack = 1'b1; isr_done = 1'b1;
      tick();
      int_ack = 1'b0; isr_done = 1'b0;
      check("t5_req_drop", 8'(int_req), 8'd0);
      check("t5_cur", 8'(cur_isr), 8'd0);
      check("t5_pend_kept", 8'(pend), 8'h02);
      tick();
      check("t5_rereq", 8'(int_req), 8'd1);
      check("t5_vec", 8'(int_vec), 8'd2);
      irq = 3'b000; tick();
      irq = 3'b010; int_ack = 1'b1;
      tick();
      int_ack = 1'b0;
      check("t5_grant_cur", 8'(cur_isr), 8'(exp_q.size() > 0 ? exp_q.pop_front() : 3'd0));
      exp_q.push_back(3'd2);
      check("t5_pend_set_wins", 8'(pend), 8'h02);
      done("t5a", 3'd0);
      grant("t5b");
      done("t5b", 3'd0);
      irq = '0; tick();

      // async reset in fast service, held inputs not captured after release
      irq = 3'b100; exp_q.push_back(3'd1);
      grant("t6n");
      firq = 3'b010; exp_q.push_back(3'd5);
`ifdef FIQ_NEST_EN
      grant("t6f");
      check("t6_nested", 8'(nested), 8'd1);
`else
      done("t6n", 3'd0);
      grant("t6f");
`endif
      irq = 3'b111;
      #3 reset_n = 1'b0;
      #1;
      check("t6_rst_req", 8'(int_req), 8'd0);
      check("t6_rst_vec", 8'(int_vec), 8'd0);
      check("t6_rst_cur", 8'(cur_isr), 8'd0);
      check("t6_rst_pend", 8'(pend), 8'd0);
      check("t6_rst_nested", 8'(nested), 8'd0);
      tick();
      reset_n = 1'b1;
      tick(); tick(); tick(); tick();
      check("t6_held_req", 8'(int_req), 8'd0);
      check("t6_held_pend", 8'(pend), 8'd0);
      irq = 3'b000; tick();
      irq = 3'b111; tick();
      check("t6_recapture", 8'(pend), 8'h07);
      tick();
      check("t6_req_after", 8'(int_req), 8'd1);
      check("t6_vec_after", 8'(int_vec), 8'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
